// File: rtl/raw8_frame_tx.sv
// raw8 stream transmitter: pops pixel words from an upstream FIFO and
// regenerates frame_start / line bursts / hblank / frame_end / vblank timing.
//
// Ports:
//   I_clk, I_rst_n        clock, asynchronous active-low reset
//   I_en                  frame enable, sampled in IDLE and at end of VBL
//   I_line_avail          upstream holds at least one full line of words
//   I_pix_valid/_data     upstream word and its valid flag
//   O_pix_ready           pop strobe to upstream (high in every LINE cycle)
//   I_clr_err             clears the sticky underflow flag
//   O_raw8_frame_start    one-cycle frame start pulse
//   O_raw8_frame_end      one-cycle frame end pulse
//   O_raw8_valid/_data    output word, data forced to zero when not valid
//   O_busy                frame in progress
//   O_underflow           sticky mid-line starvation flag
module raw8_frame_tx #(
    parameter int WORDS_PER_LINE  = 480,
    parameter int LINES_PER_FRAME = 1080,
    parameter int HBLANK_MIN      = 16,
    parameter int FS_GAP          = 4,
    parameter int VBLANK          = 32
) (
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic        I_en,
    input  logic        I_line_avail,
    input  logic        I_pix_valid,
    input  logic [31:0] I_pix_data,
    output logic        O_pix_ready,
    input  logic        I_clr_err,
    output logic        O_raw8_frame_start,
    output logic        O_raw8_frame_end,
    output logic        O_raw8_valid,
    output logic [31:0] O_raw8_data,
    output logic        O_busy,
    output logic        O_underflow
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FS,
        S_GAP,
        S_WAIT_LINE,
        S_LINE,
        S_HBLANK,
        S_FE,
        S_VBL
    } state_t;

    localparam logic [11:0] WORD_LAST = 12'(WORDS_PER_LINE - 1);
    localparam logic [11:0] LINES_ALL = 12'(LINES_PER_FRAME);
    localparam logic [11:0] HB_LAST   = 12'(HBLANK_MIN - 1);
    localparam logic [11:0] GAP_LAST  = 12'(FS_GAP - 1);
    localparam logic [11:0] VB_LAST   = 12'(VBLANK - 1);

    state_t      state_q, state_d;
    state_t      line_entry;
    logic [11:0] col_q, col_d;
    logic [11:0] line_q, line_d;
    logic [11:0] cnt_q, cnt_d;

    logic        fs_q, fs_d;
    logic        fe_q, fe_d;
    logic        valid_q, valid_d;
    logic [31:0] data_q, data_d;
    logic        busy_q, busy_d;
    logic        uf_q, uf_d;

    // A line that is already available starts without a WAIT_LINE cycle,
    // so back-to-back lines are separated by exactly HBLANK_MIN cycles.
    assign line_entry = I_line_avail ? S_LINE : S_WAIT_LINE;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        line_d  = line_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (I_en) begin
                    state_d = S_FS;
                end
            end
            S_FS: begin
                line_d = '0;
                cnt_d  = '0;
                if (FS_GAP == 0) begin
                    state_d = line_entry;
                end else begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = line_entry;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            S_WAIT_LINE: begin
                if (I_line_avail) begin
                    state_d = S_LINE;
                end
            end
            S_LINE: begin
                if (col_q == WORD_LAST) begin
                    col_d   = '0;
                    line_d  = line_q + 12'd1;
                    cnt_d   = '0;
                    state_d = S_HBLANK;
                end else begin
                    col_d = col_q + 12'd1;
                end
            end
            S_HBLANK: begin
                if (cnt_q == HB_LAST) begin
                    cnt_d = '0;
                    if (line_q == LINES_ALL) begin
                        state_d = S_FE;
                    end else begin
                        state_d = line_entry;
                    end
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            S_FE: begin
                cnt_d = '0;
                if (VBLANK == 0) begin
                    state_d = I_en ? S_FS : S_IDLE;
                end else begin
                    state_d = S_VBL;
                end
            end
            S_VBL: begin
                if (cnt_q == VB_LAST) begin
                    cnt_d   = '0;
                    state_d = I_en ? S_FS : S_IDLE;
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output stage: everything except the pop strobe is one cycle behind
    // the state, so each popped word appears on the next cycle.
    always_comb begin
        fs_d    = (state_q == S_FS);
        fe_d    = (state_q == S_FE);
        valid_d = (state_q == S_LINE);
        data_d  = '0;
        if ((state_q == S_LINE) && I_pix_valid) begin
            data_d = I_pix_data;
        end
        // A fresh starvation wins over a same-cycle clear.
        uf_d   = ((state_q == S_LINE) && !I_pix_valid) ||
                 (uf_q && !I_clr_err);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            line_q  <= '0;
            cnt_q   <= '0;
            fs_q    <= 1'b0;
            fe_q    <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            line_q  <= line_d;
            cnt_q   <= cnt_d;
            fs_q    <= fs_d;
            fe_q    <= fe_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            uf_q    <= uf_d;
        end
    end

    assign O_pix_ready        = (state_q == S_LINE);
    assign O_raw8_frame_start = fs_q;
    assign O_raw8_frame_end   = fe_q;
    assign O_raw8_valid       = valid_q;
    assign O_raw8_data        = data_q;
    assign O_busy             = busy_q;
    assign O_underflow        = uf_q;

endmodule

// File: doc/raw8_frame_tx.md
Name: raw8_frame_tx

Overview:
- Transmitter for the raw8 video stream interface: frame_start pulse, per-line contiguous valid bursts of 32-bit words (4 pixels per word), frame_end pulse.
- Pulls words from an upstream pixel FIFO and regenerates frame/line timing, including blanking.
- Sits at the output of the tile buffer. It feeds the cropping stage and downstream consumers, which detect line ends on the falling edge of valid.

Parameters:
- WORDS_PER_LINE, 480, valid words per line (1..4095).
- LINES_PER_FRAME, 1080, lines per frame (1..4095).
- HBLANK_MIN, 16, minimum valid-low cycles after each line (1..4095).
- FS_GAP, 4, idle cycles between frame_start and the earliest first-line word (0..4095).
- VBLANK, 32, idle cycles after frame_end before the next frame_start (0..4095).

Ports:
- I_clk  in  1  clock.
- I_rst_n  in  1  reset, asynchronous, active-low.
- I_en  in  1  enable frame generation; sampled only at frame boundaries.
- I_line_avail  in  1  upstream holds at least WORDS_PER_LINE words.
- I_pix_valid  in  1  upstream word valid.
- I_pix_data  in  32  upstream word.
- O_pix_ready  out  1  pop strobe to upstream.
- I_clr_err  in  1  clears O_underflow.
- O_raw8_frame_start  out  1  one-cycle frame start pulse.
- O_raw8_frame_end  out  1  one-cycle frame end pulse.
- O_raw8_valid  out  1  output word valid.
- O_raw8_data  out  32  output word; zero when valid is low.
- O_busy  out  1  a frame is in progress (not IDLE).
- O_underflow  out  1  sticky mid-line starvation flag.

Behaviour:
- Reset (asynchronous, active-low): state IDLE; all counters 0; every output 0. Reset mid-frame aborts immediately, with no frame_end.
- All outputs are registered.
- States: IDLE, FS, GAP, WAIT_LINE, LINE, HBLANK, FE, VBL.
- IDLE: if I_en=1, go to FS.
- FS: lasts 1 cycle; O_raw8_frame_start=1 for exactly this cycle. Then go to GAP, or to WAIT_LINE if FS_GAP=0.
- GAP: stay FS_GAP cycles, then go to WAIT_LINE.
- WAIT_LINE: wait for I_line_avail=1, then go to LINE. Wait time is unbounded; valid stays low.
- LINE:
  - O_pix_ready=1 (combinational from state) for exactly WORDS_PER_LINE consecutive cycles.
  - Each LINE cycle registers the result to the outputs next cycle, so latency is 1 cycle:
    - O_raw8_valid=1.
    - O_raw8_data=I_pix_data if I_pix_valid=1.
    - Otherwise O_raw8_data=0 and O_underflow set.
  - Valid is never deasserted mid-line. Each line is exactly WORDS_PER_LINE contiguous valid cycles.
- HBLANK: valid low for exactly HBLANK_MIN cycles after the last word of the line. The line counter increments at the end of the line.
  - If lines sent < LINES_PER_FRAME: go to WAIT_LINE.
  - Else: go to FE.
- FE: lasts 1 cycle; O_raw8_frame_end=1.
- VBL: VBLANK cycles idle. Then go to FS if I_en=1, else IDLE.
- I_en deasserted mid-frame: the current frame completes normally. I_en is checked only in IDLE and at the end of VBL.
- Frame period with I_line_avail held high: 1 + FS_GAP + LINES_PER_FRAME*(WORDS_PER_LINE+HBLANK_MIN) + 1 + VBLANK cycles.
- O_underflow: sticky. Cleared by I_clr_err. If I_clr_err and a new underflow occur in the same cycle, set wins.
- O_busy=1 in every state except IDLE.
- O_pix_ready=0 outside LINE. I_pix_valid outside LINE is ignored and nothing is popped.
- Counters: 12-bit for column, line and blanking.
  - Column counter wraps to 0 at the end of each line.
  - Line counter clears in FS.
- Data is passed bit-exact with no byte reordering.

Test Plan:
- Params W=4, L=3, HB=2, FS_GAP=1, VB=3; I_en=1, I_line_avail=1, source always valid with incrementing data 0x00000001..
  - Required: frame_start at cycle T.
  - Valid bursts of 4 at T+2..T+5, T+8..T+11, T+14..T+17, with data 1..12 in order.
  - frame_end at T+20; next frame_start at T+24.
- Same params, I_line_avail low for 5 cycles before line 2: valid stays low 2+5 cycles between lines 1 and 2, with no other timing change.
- I_pix_valid dropped for 1 cycle mid-line 1: O_raw8_valid stays high, that word=0x00000000, O_underflow=1 and holds until I_clr_err; line length is still 4.
- I_en dropped during line 2: frame completes with frame_end; after VBL, state is IDLE, O_busy=0, no further frame_start.
- I_rst_n asserted low during line 1: all outputs 0 immediately. After release with I_en=1, a clean frame starts with frame_start and the line counter at 0.
- I_clr_err coincident with an underflow cycle: O_underflow remains 1.
